adc_joystick_sequencer: RTL and testbench

//  Sequences the on-chip modular ADC for the joystick. Issues conversion commands alternately
//  on the Y and X channels using the Avalon-ST command/response handshake, and matches each

---
 rtl/adc_joystick_sequencer.sv | 110 +++++++++++
 tb/tb_adc_joystick_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_joystick_sequencer.sv
// Joystick ADC sequencer: alternates Y/X conversions, averages 2**AVG_LOG2 samples per axis; outputs update 1 cycle after the accepting response.
// Command held stable under cmd_ready backpressure; a lost response is re-requested after TIMEOUT idle cycles.
module adc_joystick_sequencer #(
    parameter int Y_CH     = 1,
    parameter int X_CH     = 2,
    parameter int AVG_LOG2 = 2,
    parameter int TIMEOUT  = 1023
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic        cmd_valid,
    output logic [4:0]  cmd_channel,
    input  logic        cmd_ready,
    input  logic        rsp_valid,
    input  logic [4:0]  rsp_channel,
    input  logic [11:0] rsp_data,
    output logic [11:0] y_val,
    output logic [11:0] x_val,
    output logic        sample_strobe,
    output logic        timeout_err
);
    localparam int ACC_W  = 12 + AVG_LOG2;
    localparam int CNT_W  = AVG_LOG2 + 1;
    localparam int WDOG_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [4:0] Y_SEL = 5'(Y_CH);
    localparam logic [4:0] X_SEL = 5'(X_CH);

    typedef enum logic {ST_ISSUE, ST_WAIT} state_t;

    state_t             state;
    logic [4:0]         cur;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic [WDOG_W-1:0]  wdog;

    logic [ACC_W-1:0]   acc_sum;
    logic [CNT_W-1:0]   cnt_inc;
    logic [11:0]        avg;
    logic [4:0]         next_ch;
    logic               rsp_match;
    logic               last_sample;

    assign acc_sum     = acc + ACC_W'(rsp_data);
    assign cnt_inc     = cnt + CNT_W'(1);
    assign avg         = 12'(acc_sum >> AVG_LOG2);
    assign next_ch     = (cur == Y_SEL) ? X_SEL : Y_SEL;
    assign rsp_match   = rsp_valid && (rsp_channel == cur);
    assign last_sample = (cnt_inc == CNT_W'(1 << AVG_LOG2));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state         <= ST_ISSUE;
            cur           <= Y_SEL;
            acc           <= '0;
            cnt           <= '0;
            wdog          <= '0;
            cmd_valid     <= 1'b0;
            cmd_channel   <= Y_SEL;
            y_val         <= 12'h800;
            x_val         <= 12'h800;
            sample_strobe <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            sample_strobe <= 1'b0;
            case (state)
                ST_ISSUE: begin
                    if (cmd_valid && cmd_ready) begin
                        state     <= ST_WAIT;
                        cmd_valid <= 1'b0;
                        wdog      <= '0;
                    end else begin
                        cmd_valid   <= 1'b1;
                        cmd_channel <= cur;
                    end
                end
                ST_WAIT: begin
                    // A matching response beats the watchdog on the same edge.
                    if (rsp_match) begin
                        state     <= ST_ISSUE;
                        cmd_valid <= 1'b1;
                        if (last_sample) begin
                            acc         <= '0;
                            cnt         <= '0;
                            cur         <= next_ch;
                            cmd_channel <= next_ch;
                            if (cur == Y_SEL) begin
                                y_val <= avg;
                            end else begin
                                x_val         <= avg;
                                sample_strobe <= 1'b1;
                            end
                        end else begin
                            acc         <= acc_sum;
                            cnt         <= cnt_inc;
                            cmd_channel <= cur;
                        end
                    end else if (wdog == WDOG_W'(TIMEOUT)) begin
                        timeout_err <= 1'b1;
                        state       <= ST_ISSUE;
                        cmd_valid   <= 1'b1;
                        cmd_channel <= cur;
                    end else begin
                        wdog <= wdog + WDOG_W'(1);
                    end
                end
                default: state <= ST_ISSUE;
            endcase
        end
    end
endmodule

// File: tb/tb_adc_joystick_sequencer.sv
// Directed bench: dut averages 4 samples per axis, dut_a has averaging disabled.
module tb_adc_joystick_sequencer;
    logic        Clk = 1'b0;
    logic        Reset;

    logic        cmd_valid, cmd_ready, rsp_valid, sample_strobe, timeout_err;
    logic [4:0]  cmd_channel, rsp_channel;
    logic [11:0] rsp_data, y_val, x_val;

    logic        cmd_valid_a, cmd_ready_a, rsp_valid_a, sample_strobe_a, timeout_err_a;
    logic [4:0]  cmd_channel_a, rsp_channel_a;
    logic [11:0] rsp_data_a, y_val_a, x_val_a;

    int tests = 0;
    int fails = 0;
    int strobe_cnt = 0;
    int strobe_cnt_a = 0;

    localparam logic [4:0] YC = 5'd1;
    localparam logic [4:0] XC = 5'd2;

    adc_joystick_sequencer #(.Y_CH(1), .X_CH(2), .AVG_LOG2(2), .TIMEOUT(1023)) dut (
        .Clk(Clk), .Reset(Reset),
        .cmd_valid(cmd_valid), .cmd_channel(cmd_channel), .cmd_ready(cmd_ready),
        .rsp_valid(rsp_valid), .rsp_channel(rsp_channel), .rsp_data(rsp_data),
        .y_val(y_val), .x_val(x_val),
        .sample_strobe(sample_strobe), .timeout_err(timeout_err)
    );

    adc_joystick_sequencer #(.Y_CH(1), .X_CH(2), .AVG_LOG2(0), .TIMEOUT(1023)) dut_a (
        .Clk(Clk), .Reset(Reset),
        .cmd_valid(cmd_valid_a), .cmd_channel(cmd_channel_a), .cmd_ready(cmd_ready_a),
        .rsp_valid(rsp_valid_a), .rsp_channel(rsp_channel_a), .rsp_data(rsp_data_a),
        .y_val(y_val_a), .x_val(x_val_a),
        .sample_strobe(sample_strobe_a), .timeout_err(timeout_err_a)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (sample_strobe === 1'b1) strobe_cnt++;
        if (sample_strobe_a === 1'b1) strobe_cnt_a++;
    end

    task automatic accept_cmd(input logic [4:0] ch, input string name);
        int n = 0;
        cmd_ready = 1'b1;
        while (cmd_valid !== 1'b1 && n < 50) begin
            @(negedge Clk);
            n++;
        end
        tests++;
        if (cmd_valid !== 1'b1 || cmd_channel !== ch) begin
            fails++;
            $display("FAIL %s: cmd_valid=%b cmd_channel=%0d, required 1/%0d", name, cmd_valid, cmd_channel, ch);
        end
        @(negedge Clk);
        cmd_ready = 1'b0;
    endtask

    task automatic respond(input logic [4:0] ch, input logic [11:0] d);
        rsp_valid   = 1'b1;
        rsp_channel = ch;
        rsp_data    = d;
        @(negedge Clk);
        rsp_valid   = 1'b0;
    endtask

    task automatic sample(input logic [4:0] ch, input logic [11:0] d, input int dly, input string name);
        accept_cmd(ch, name);
        repeat (dly) @(negedge Clk);
        respond(ch, d);
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_channel = '0; rsp_data = '0;
        cmd_ready_a = 1'b0; rsp_valid_a = 1'b0; rsp_channel_a = '0; rsp_data_a = '0;
        repeat (3) @(negedge Clk);
        tests++;
        if ({cmd_valid, cmd_channel, sample_strobe, timeout_err} !== {1'b0, YC, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_ctrl: valid/ch/strobe/terr=%b/%0d/%b/%b, required 0/1/0/0",
                     cmd_valid, cmd_channel, sample_strobe, timeout_err);
        end
        tests++;
        if (y_val !== 12'h800 || x_val !== 12'h800) begin
            fails++;
            $display("FAIL reset_vals: y=%h x=%h, required 800/800", y_val, x_val);
        end
        tests++;
        if ({cmd_valid_a, cmd_channel_a, sample_strobe_a, timeout_err_a, y_val_a, x_val_a}
            !== {1'b0, YC, 1'b0, 1'b0, 12'h800, 12'h800}) begin
            fails++;
            $display("FAIL reset_a: valid=%b ch=%0d y=%h x=%h, required 0/1/800/800",
                     cmd_valid_a, cmd_channel_a, y_val_a, x_val_a);
        end
        Reset = 1'b0;
    endtask

    task automatic test_no_avg();
        logic [4:0]  ch;
        logic [11:0] d;
        int n;
        strobe_cnt_a = 0;
        for (int i = 0; i < 2; i++) begin
            ch = (i == 0) ? YC : XC;
            d  = (i == 0) ? 12'h123 : 12'h456;
            n  = 0;
            cmd_ready_a = 1'b1;
            while (cmd_valid_a !== 1'b1 && n < 50) begin
                @(negedge Clk);
                n++;
            end
            tests++;
            if (cmd_valid_a !== 1'b1 || cmd_channel_a !== ch) begin
                fails++;
                $display("FAIL noavg_cmd%0d: valid=%b ch=%0d, required 1/%0d", i, cmd_valid_a, cmd_channel_a, ch);
            end
            @(negedge Clk);
            cmd_ready_a = 1'b0;
            repeat (3) @(negedge Clk);
            rsp_valid_a = 1'b1; rsp_channel_a = ch; rsp_data_a = d;
            @(negedge Clk);
            rsp_valid_a = 1'b0;
            tests++;
            if (i == 0) begin
                if ({y_val_a, x_val_a, sample_strobe_a} !== {12'h123, 12'h800, 1'b0}) begin
                    fails++;
                    $display("FAIL noavg_y: y=%h x=%h strobe=%b, required 123/800/0", y_val_a, x_val_a, sample_strobe_a);
                end
            end else begin
                if ({y_val_a, x_val_a, sample_strobe_a} !== {12'h123, 12'h456, 1'b1}) begin
                    fails++;
                    $display("FAIL noavg_x: y=%h x=%h strobe=%b, required 123/456/1", y_val_a, x_val_a, sample_strobe_a);
                end
            end
        end
        repeat (5) @(negedge Clk);
        tests++;
        if (strobe_cnt_a != 1) begin
            fails++;
            $display("FAIL noavg_strobe_count: got %0d, required 1", strobe_cnt_a);
        end
    endtask

    task automatic test_averaging();
        strobe_cnt = 0;
        sample(YC, 12'd100, 2, "avg_y0");
        sample(YC, 12'd101, 2, "avg_y1");
        sample(YC, 12'd102, 2, "avg_y2");
        tests++;
        if (y_val !== 12'h800) begin
            fails++;
            $display("FAIL avg_y_early: y=%0d, required 2048", y_val);
        end
        sample(YC, 12'd105, 2, "avg_y3");
        tests++;
        if ({y_val, x_val, sample_strobe} !== {12'd102, 12'h800, 1'b0}) begin
            fails++;
            $display("FAIL avg_y: y=%0d x=%h strobe=%b, required 102/800/0", y_val, x_val, sample_strobe);
        end
        sample(XC, 12'd1000, 1, "avg_x0");
        sample(XC, 12'd1001, 1, "avg_x1");
        sample(XC, 12'd1002, 1, "avg_x2");
        tests++;
        if (x_val !== 12'h800 || strobe_cnt != 0) begin
            fails++;
            $display("FAIL avg_x_early: x=%h strobes=%0d, required 800/0", x_val, strobe_cnt);
        end
        sample(XC, 12'd1003, 1, "avg_x3");
        tests++;
        if ({y_val, x_val, sample_strobe} !== {12'd102, 12'd1001, 1'b1}) begin
            fails++;
            $display("FAIL avg_x: y=%0d x=%0d strobe=%b, required 102/1001/1", y_val, x_val, sample_strobe);
        end
        @(negedge Clk);
        tests++;
        if (sample_strobe !== 1'b0 || strobe_cnt != 1) begin
            fails++;
            $display("FAIL avg_strobe_pulse: strobe=%b count=%0d, required 0/1", sample_strobe, strobe_cnt);
        end
    endtask

    task automatic test_cmd_stall();
        int bad = 0;
        cmd_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            if (cmd_valid !== 1'b1 || cmd_channel !== YC) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL stall_hold: %0d unstable cycles, required 0", bad);
        end
        cmd_ready = 1'b1;
        @(negedge Clk);
        cmd_ready = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (cmd_valid !== 1'b0) bad++;
            @(negedge Clk);
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL stall_single_accept: cmd_valid high %0d cycles after accept, required 0", bad);
        end
        respond(YC, 12'd200);
    endtask

    task automatic test_timeout();
        int n;
        accept_cmd(YC, "to_cmd");
        respond(5'd5, 12'hFFF);
        n = 1;
        while (cmd_valid !== 1'b1 && n < 1200) begin
            @(negedge Clk);
            n++;
        end
        tests++;
        if (n != 1024) begin
            fails++;
            $display("FAIL to_latency: reissue after %0d cycles, required 1024", n);
        end
        tests++;
        if (timeout_err !== 1'b1 || cmd_channel !== YC) begin
            fails++;
            $display("FAIL to_flag: timeout_err=%b ch=%0d, required 1/1", timeout_err, cmd_channel);
        end
        sample(YC, 12'd300, 1, "to_y1");
        sample(YC, 12'd400, 1, "to_y2");
        tests++;
        if (y_val !== 12'd102) begin
            fails++;
            $display("FAIL to_acc_kept: y=%0d, required 102", y_val);
        end
        sample(YC, 12'd600, 1, "to_y3");
        tests++;
        if (y_val !== 12'd375) begin
            fails++;
            $display("FAIL to_avg: y=%0d, required 375", y_val);
        end
    endtask

    task automatic test_reset_mid();
        sample(XC, 12'd50, 1, "rm_x0");
        sample(XC, 12'd60, 1, "rm_x1");
        accept_cmd(XC, "rm_x2");
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        tests++;
        if ({cmd_valid, cmd_channel, sample_strobe, timeout_err, y_val, x_val}
            !== {1'b0, YC, 1'b0, 1'b0, 12'h800, 12'h800}) begin
            fails++;
            $display("FAIL rm_outputs: valid=%b ch=%0d terr=%b y=%h x=%h, required 0/1/0/800/800",
                     cmd_valid, cmd_channel, timeout_err, y_val, x_val);
        end
        Reset = 1'b0;
        sample(YC, 12'd10, 1, "rm_y0");
        sample(YC, 12'd20, 1, "rm_y1");
        sample(YC, 12'd30, 1, "rm_y2");
        tests++;
        if (y_val !== 12'h800) begin
            fails++;
            $display("FAIL rm_fresh: y=%h after 3 samples, required 800", y_val);
        end
        sample(YC, 12'd40, 1, "rm_y3");
        tests++;
        if (y_val !== 12'd25) begin
            fails++;
            $display("FAIL rm_avg: y=%0d, required 25", y_val);
        end
    endtask

    task automatic test_resp_at_timeout();
        sample(XC, 12'd5, 1023, "rt_x0");
        tests++;
        if (timeout_err !== 1'b0) begin
            fails++;
            $display("FAIL rt_flag: timeout_err=%b, required 0", timeout_err);
        end
        sample(XC, 12'd1, 1, "rt_x1");
        sample(XC, 12'd2, 1, "rt_x2");
        sample(XC, 12'd3, 1, "rt_x3");
        tests++;
        if ({x_val, sample_strobe, timeout_err} !== {12'd2, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL rt_avg: x=%0d strobe=%b terr=%b, required 2/1/0", x_val, sample_strobe, timeout_err);
        end
    endtask

    initial begin
        test_reset();
        test_no_avg();
        test_averaging();
        test_cmd_stall();
        test_timeout();
        test_reset_mid();
        test_resp_at_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
